// File: rtl/ex_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// ex_muldiv_sequencer
//   Iterative RV32M multiply/divide unit that sits beside the EX-stage ALU.
//   One M-extension op is accepted from EX, executed one bit per cycle
//   (radix-2 shift-add multiply, radix-2 restoring divide), and its result
//   is returned with the latched rd for the EX/MEM register. The pipeline
//   is frozen through stall_req while the unit owns EX.
//
// Ports
//   clk            in   1     rising-edge clock
//   rst            in   1     synchronous active-high reset
//   start          in   1     EX holds a valid M-extension instruction
//   func3          in   3     MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   op1            in   XLEN  rs1 (multiplicand / dividend)
//   op2            in   XLEN  rs2 (multiplier / divisor)
//   rd             in   5     destination register
//   pipeline_flush in   1     squash the in-flight operation
//   stall_req      out  1     freeze IF/ID/EX
//   done           out  1     one-cycle result-valid pulse
//   result         out  XLEN  result, held until the next done
//   wb_rd          out  5     destination register of the result
//   wb_reg_file    out  1     register-file write enable
// ---------------------------------------------------------------------------
module ex_muldiv_sequencer #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] op1,
  input  logic [XLEN-1:0] op2,
  input  logic [4:0]      rd,
  input  logic            pipeline_flush,
  output logic            stall_req,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_rd,
  output logic            wb_reg_file
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  // Control state (reset)
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        wb_rd_q, wb_rd_d;

  // Operand / datapath state (not reset; only observed after an accept)
  logic [2*XLEN-1:0] acc_q, acc_d;      // MUL: {hi, lo/multiplier}  DIV: {rem, quotient/dividend}
  logic [XLEN-1:0]   mcand_q, mcand_d;  // MUL: |multiplicand|       DIV: |divisor|
  logic [2:0]        func3_q, func3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;      // negate product / quotient
  logic              rem_neg_q, rem_neg_d;

  // Operand decode
  logic signed [XLEN-1:0] op1_s, op2_s;
  logic              is_div, op1_signed, op2_signed, s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_by_zero, div_ovf, accept;
  logic [XLEN:0]     mul_sum, div_shift, div_trial;
  logic [XLEN-1:0]   final_word;

  function automatic logic [XLEN-1:0] abs_mag(input logic [XLEN-1:0] v, input logic neg);
    abs_mag = neg ? -v : v;
  endfunction

  // Sign fix-up and output word selection for a finished operation.
  function automatic logic [XLEN-1:0] fixup(input logic [2*XLEN-1:0] acc,
                                            input logic [2:0]        f3,
                                            input logic              neg,
                                            input logic              rem_neg);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   q, r;
    prod = neg ? -acc : acc;
    q    = neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r    = rem_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    if (f3[2])
      fixup = f3[1] ? r : q;
    else
      fixup = (f3[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    op1_s      = op1;
    op2_s      = op2;
    is_div     = func3[2];
    // MUL/MULH/MULHSU treat op1 as signed, MUL/MULH treat op2 as signed;
    // DIV/REM are signed, DIVU/REMU unsigned.
    op1_signed = is_div ? ~func3[0] : (func3[1:0] != 2'b11);
    op2_signed = is_div ? ~func3[0] : ~func3[1];
    s1         = op1_signed & (op1_s < 0);
    s2         = op2_signed & (op2_s < 0);
    mag1       = abs_mag(op1, s1);
    mag2       = abs_mag(op2, s2);
    div_by_zero = is_div & (op2 == '0);
    div_ovf     = is_div & ~func3[0] & (op1 == {1'b1, {(XLEN-1){1'b0}}}) & (op2 == '1);
    accept      = (state_q == S_IDLE) & start & ~pipeline_flush;
    final_word  = fixup(acc_q, func3_q, neg_q, rem_neg_q);
  end

  // ---- state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      wb_rd_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      wb_rd_q  <= wb_rd_d;
    end
    acc_q     <= acc_d;
    mcand_q   <= mcand_d;
    func3_q   <= func3_d;
    rd_q      <= rd_d;
    neg_q     <= neg_d;
    rem_neg_q <= rem_neg_d;
  end

  // ---- next-state logic ----
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (div_by_zero | div_ovf) state_d = S_DONE;
          else if (is_div)           state_d = S_DIV;
          else                       state_d = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (pipeline_flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- datapath: operand latch, iteration step, result capture ----
  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    func3_d   = func3_q;
    rd_d      = rd_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    result_d  = result_q;
    wb_rd_d   = wb_rd_q;

    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_trial = div_shift - {1'b0, mcand_q};

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          func3_d   = func3;
          rd_d      = rd;
          neg_d     = s1 ^ s2;
          rem_neg_d = s1;
          mcand_d   = is_div ? mag2 : mag1;
          acc_d     = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
          // Fast paths preload the final {rem, quotient} with no sign fix-up.
          if (div_by_zero) begin
            acc_d     = {op1, {XLEN{1'b1}}};
            neg_d     = 1'b0;
            rem_neg_d = 1'b0;
          end else if (div_ovf) begin
            acc_d     = {{XLEN{1'b0}}, op1};
            neg_d     = 1'b0;
            rem_neg_d = 1'b0;
          end
        end
      end
      S_MUL: acc_d = {mul_sum, acc_q[XLEN-1:1]};
      S_DIV: begin
        // Restore (keep the shifted remainder) when the trial subtraction borrows.
        if (!div_trial[XLEN])
          acc_d = {div_trial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
          acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
      S_DONE: begin
        result_d = final_word;
        wb_rd_d  = rd_q;
      end
      default: ;
    endcase
  end

  // ---- outputs ----
  always_comb begin
    stall_req   = accept | (state_q == S_MUL) | (state_q == S_DIV);
    done        = (state_q == S_DONE);
    result      = done ? final_word : result_q;
    wb_rd       = done ? rd_q : wb_rd_q;
    // A flush arriving with the result squashes the register write only.
    wb_reg_file = done & (wb_rd != 5'd0) & ~pipeline_flush;
  end

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
module tb_ex_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, pipeline_flush;
  logic [2:0]  func3;
  logic [31:0] op1, op2;
  logic [4:0]  rd;
  logic        stall_req, done, wb_reg_file;
  logic [31:0] result;
  logic [4:0]  wb_rd;

  ex_muldiv_sequencer #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3), .op1(op1), .op2(op2),
    .rd(rd), .pipeline_flush(pipeline_flush), .stall_req(stall_req), .done(done),
    .result(result), .wb_rd(wb_rd), .wb_reg_file(wb_reg_file)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011,
                         F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        wr;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int stall_total = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals done.
  always @(negedge clk) begin : mon
    exp_t e;
    if (stall_req === 1'b1) stall_total <= stall_total + 1;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d, want no done", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, result, e.res);
        check({e.name, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
        check({e.name, "_wb_reg_file"}, {31'd0, wb_reg_file}, {31'd0, e.wr});
        check({e.name, "_latency"}, cyc, e.due);
      end
    end
  end

  // Drive one op for one cycle; optionally queue its expected response.
  task automatic issue(input string name, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp_res,
                       input bit fast, input bit expect_done, input bit kill_wr);
    exp_t e;
    @(posedge clk); #1;
    start = 1'b1; func3 = f; op1 = a; op2 = b; rd = r;
    if (expect_done) begin
      e.res = exp_res; e.rd = r; e.wr = (r != 5'd0) && !kill_wr;
      e.due = cyc + (fast ? 1 : 33); e.name = name;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d pending, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input string name, input logic [2:0] f, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp_res,
                     input bit fast);
    issue(name, f, a, b, r, exp_res, fast, 1'b1, 1'b0);
    wait_drain(name);
    check({name, "_hold"}, result, exp_res);
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check({name, "_done_seen"}, {31'd0, seen}, 32'd1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_stall_req"}, {31'd0, stall_req}, 32'd0);
    check({name, "_done"}, {31'd0, done}, 32'd0);
    check({name, "_result"}, result, 32'd0);
    check({name, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    check({name, "_wb_reg_file"}, {31'd0, wb_reg_file}, 32'd0);
  endtask

  initial begin
    int s0;
    rst = 1'b1; start = 1'b0; pipeline_flush = 1'b0;
    func3 = 3'd0; op1 = 32'd0; op2 = 32'd0; rd = 5'd0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // MUL 7 * -3 with stall window measurement
    s0 = stall_total;
    run("mul_neg", F_MUL, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, 1'b0);
    check("mul_stall_cycles", stall_total - s0, 32'd33);

    run("mulhu_m1", F_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, 1'b0);
    run("mulh_m1",  F_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, 1'b0);
    run("mulhsu",   F_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, 1'b0);
    run("mulh_min", F_MULH,   32'h8000_0000, 32'h8000_0000, 5'd5, 32'h4000_0000, 1'b0);
    run("div_neg",  F_DIV,    32'hFFFF_FFF9, 32'd2,         5'd6, 32'hFFFF_FFFD, 1'b0);
    run("rem_neg",  F_REM,    32'hFFFF_FFF9, 32'd2,         5'd7, 32'hFFFF_FFFF, 1'b0);
    run("div_negd", F_DIV,    32'd7,         32'hFFFF_FFFE, 5'd8, 32'hFFFF_FFFD, 1'b0);
    run("rem_negd", F_REM,    32'd7,         32'hFFFF_FFFE, 5'd8, 32'h0000_0001, 1'b0);
    run("divu",     F_DIVU,   32'd100,       32'd7,         5'd9, 32'd14,        1'b0);
    run("remu",     F_REMU,   32'd100,       32'd7,         5'd9, 32'd2,         1'b0);

    // Fast paths
    run("divu_zero", F_DIVU, 32'd5,         32'd0,         5'd10, 32'hFFFF_FFFF, 1'b1);
    run("rem_zero",  F_REM,  32'd5,         32'd0,         5'd11, 32'd5,         1'b1);
    run("div_ovf",   F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b1);
    run("rem_ovf",   F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'd0,         1'b1);

    // Flush during iteration 10: no done, stall released next cycle
    issue("flushed", F_DIV, 32'd1000, 32'd3, 5'd14, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    pipeline_flush = 1'b1;
    @(posedge clk); #1;
    pipeline_flush = 1'b0;
    check("flush_stall_req", {31'd0, stall_req}, 32'd0);
    check("flush_done", {31'd0, done}, 32'd0);
    repeat (40) @(posedge clk);
    run("mul_after_flush", F_MUL, 32'd3, 32'd4, 5'd15, 32'd12, 1'b0);

    // Start together with flush in IDLE is not accepted
    @(posedge clk); #1;
    start = 1'b1; pipeline_flush = 1'b1; func3 = F_MUL; op1 = 32'd9; op2 = 32'd9; rd = 5'd16;
    check("idle_flush_stall", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; pipeline_flush = 1'b0;
    check("idle_flush_stall_next", {31'd0, stall_req}, 32'd0);
    check("idle_flush_done", {31'd0, done}, 32'd0);
    repeat (5) @(posedge clk);

    // rd = 0 executes but does not write
    run("mul_rd0", F_MUL, 32'd2, 32'd3, 5'd0, 32'd6, 1'b0);

    // Flush in the DONE cycle: done pulses, write suppressed
    issue("flush_in_done", F_MUL, 32'd5, 32'd6, 5'd9, 32'd30, 1'b0, 1'b1, 1'b1);
    wait_done("flush_in_done");
    pipeline_flush = 1'b1;
    @(posedge clk); #1;
    pipeline_flush = 1'b0;
    wait_drain("flush_in_done");
    check("flush_in_done_hold", result, 32'd30);

    // Reset in the middle of a DIV
    issue("rst_div", F_DIV, 32'd500, 32'd7, 5'd17, 32'd0, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("rst_mid_div");
    rst = 1'b0;
    repeat (40) @(posedge clk);

    // Back-to-back: MUL presented the cycle after DIVU's done
    issue("b2b_divu", F_DIVU, 32'd100, 32'd7, 5'd18, 32'd14, 1'b0, 1'b1, 1'b0);
    wait_done("b2b_divu");
    issue("b2b_mul", F_MUL, 32'd3, 32'd4, 5'd19, 32'd12, 1'b0, 1'b1, 1'b0);
    wait_drain("b2b");
    check("b2b_hold", result, 32'd12);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
